// File: rtl/alzette_dec_iter.sv
// alzette_dec_iter: iterative Alzette inverse, QPC quarters per cycle, valid/ready on both sides
module alzette_dec_iter #(
    parameter int QPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [2:0]  in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y
);

    if (!(QPC == 1 || QPC == 2 || QPC == 4)) begin : g_bad_qpc
        $error("alzette_dec_iter: QPC must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] RC [8] = '{
        32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
        32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D
    };

    state_t      state, state_nxt;
    logic [1:0]  qc, qc_nxt;
    logic [31:0] x, y, c, x_nxt, y_nxt;

    function automatic logic [31:0] ror(input logic [31:0] v, input logic [4:0] n);
        return 32'({v, v} >> n);
    endfunction

    // Quarter q undoes encryption round 3-q; rotation pair (a, b) is fixed per quarter.
    function automatic logic [63:0] inv_quarter(input logic [31:0] xi, input logic [31:0] yi,
                                                input logic [31:0] ci, input logic [1:0] q);
        logic [4:0]  a, b;
        logic [31:0] xt, yt;
        a  = q == 2'd0 ? 5'd16 : q == 2'd1 ? 5'd31 : q == 2'd2 ? 5'd17 : 5'd24;
        b  = q == 2'd0 ? 5'd24 : q == 2'd1 ? 5'd0  : q == 2'd2 ? 5'd17 : 5'd31;
        xt = xi ^ ci;
        yt = yi ^ ror(xt, a);
        xt = xt - ror(yt, b);
        return {xt, yt};
    endfunction

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_x     = x;
    assign out_y     = y;
    assign qc_nxt    = qc + 2'(QPC);

    // Chain QPC consecutive quarters starting at qc; the 2-bit index wraps naturally.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        for (int k = 0; k < QPC; k++)
            {x_nxt, y_nxt} = inv_quarter(x_nxt, y_nxt, c, qc + 2'(k));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: finish RUN once the quarter counter wraps back to zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (qc_nxt == 2'd0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured only on acceptance and evolve only while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x  <= '0;
            y  <= '0;
            c  <= '0;
            qc <= '0;
        end else if (state == IDLE && in_valid) begin
            x  <= in_x;
            y  <= in_y;
            c  <= RC[in_imm];
            qc <= '0;
        end else if (state == RUN) begin
            x  <= x_nxt;
            y  <= y_nxt;
            qc <= qc_nxt;
        end
    end

endmodule

// File: tb/tb_alzette_dec_iter.sv
// tb_alzette_dec_iter: model-checked bench over three instances (QPC 1, 2, 4)
module tb_alzette_dec_iter;

    localparam logic [31:0] RC [8] = '{
        32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
        32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D
    };
    localparam int LAT [3] = '{4, 2, 1};
    localparam int ER1 [4] = '{31, 17, 0, 24};
    localparam int ER2 [4] = '{24, 17, 31, 16};
    localparam int DA  [4] = '{16, 31, 17, 24};
    localparam int DB  [4] = '{24, 0, 17, 31};

    logic        clk = 1'b0;
    logic        rst;
    logic        iv [3];
    logic        ir [3];
    logic [31:0] ix [3];
    logic [31:0] iy [3];
    logic [2:0]  im [3];
    logic        ov [3];
    logic        ordy [3];
    logic [31:0] ox [3];
    logic [31:0] oy [3];

    int total = 0;
    int bad = 0;

    logic [63:0] pt_mem [3][32];
    int          wr [3];
    int          rd [3];
    bit          m_busy [3];
    int          m_cnt [3];
    logic [31:0] m_ex [3];
    logic [31:0] m_ey [3];

    always #5 clk = ~clk;

    alzette_dec_iter #(.QPC(1)) u_q1 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_x(ix[0]), .in_y(iy[0]), .in_imm(im[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_x(ox[0]), .out_y(oy[0]));
    alzette_dec_iter #(.QPC(2)) u_q2 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_x(ix[1]), .in_y(iy[1]), .in_imm(im[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_x(ox[1]), .out_y(oy[1]));
    alzette_dec_iter #(.QPC(4)) u_q4 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_x(ix[2]), .in_y(iy[2]), .in_imm(im[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_x(ox[2]), .out_y(oy[2]));

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] fwd_round(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] c, input int r1, input int r2);
        x = x + ror(y, r1);
        y = y ^ ror(x, r2);
        x = x ^ c;
        return {x, y};
    endfunction

    function automatic logic [63:0] inv_quarter(input logic [31:0] x, input logic [31:0] y,
                                                input logic [31:0] c, input int a, input int b);
        x = x ^ c;
        y = y ^ ror(x, a);
        x = x - ror(y, b);
        return {x, y};
    endfunction

    function automatic logic [63:0] enc(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
        logic [63:0] s;
        s = {x, y};
        for (int k = 0; k < 4; k++) s = fwd_round(s[63:32], s[31:0], c, ER1[k], ER2[k]);
        return s;
    endfunction

    function automatic logic [63:0] dec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
        logic [63:0] s;
        s = {x, y};
        for (int k = 0; k < 4; k++) s = inv_quarter(s[63:32], s[31:0], c, DA[k], DB[k]);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Cycle model: predicts handshake signals and result each cycle, then advances on the coming edge.
    always @(negedge clk) begin
        logic [63:0] p, e;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                rd[i] = wr[i];
                chk("rst_out_valid", 32'(ov[i]), 32'd0);
                chk("rst_out_x", ox[i], 32'd0);
                chk("rst_out_y", oy[i], 32'd0);
            end else begin
                chk("in_ready", 32'(ir[i]), 32'(!m_busy[i]));
                chk("out_valid", 32'(ov[i]), 32'(m_busy[i] && m_cnt[i] == LAT[i]));
                if (m_busy[i] && m_cnt[i] == LAT[i]) begin
                    chk("out_x_model", ox[i], m_ex[i]);
                    chk("out_y_model", oy[i], m_ey[i]);
                    if (ordy[i]) begin
                        if (rd[i] == wr[i]) begin
                            chk("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            p = pt_mem[i][rd[i] % 32];
                            rd[i]++;
                            chk("plain_x", ox[i], p[63:32]);
                            chk("plain_y", oy[i], p[31:0]);
                        end
                        m_busy[i] = 1'b0;
                    end
                end else if (m_busy[i]) begin
                    m_cnt[i]++;
                end else if (iv[i]) begin
                    e = dec(ix[i], iy[i], RC[im[i]]);
                    m_busy[i] = 1'b1;
                    m_cnt[i] = 0;
                    m_ex[i] = e[63:32];
                    m_ey[i] = e[31:0];
                end
            end
        end
    end

    task automatic wait_accept(input int i);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = ir[i];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_out(input int i);
        bit done;
        int n;
        done = 0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            done = ov[i] && ordy[i];
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("result_timeout", 32'd1, 32'd0);
    endtask

    task automatic push_req(input int i, input logic [31:0] px, input logic [31:0] py, input logic [2:0] imm);
        logic [63:0] ct;
        ct = enc(px, py, RC[imm]);
        pt_mem[i][wr[i] % 32] = {px, py};
        wr[i]++;
        ix[i] = ct[63:32];
        iy[i] = ct[31:0];
        im[i] = imm;
    endtask

    task automatic send(input int i, input logic [31:0] px, input logic [31:0] py, input logic [2:0] imm);
        push_req(i, px, py, imm);
        iv[i] = 1'b1;
        wait_accept(i);
        iv[i] = 1'b0;
    endtask

    initial begin
        logic [63:0] t;
        int n;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
            ix[i] = '0;
            iy[i] = '0;
            im[i] = '0;
            wr[i] = 0;
            rd[i] = 0;
            m_busy[i] = 1'b0;
            m_cnt[i] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        t = inv_quarter(32'd0, 32'd0, RC[0], 16, 24);
        chk("pin_q0_x", t[63:32], 32'h55297011);
        chk("pin_q0_y", t[31:0], 32'h5162B7E1);
        t = fwd_round(t[63:32], t[31:0], RC[0], 24, 16);
        chk("pin_q0_undo", t[63:32] | t[31:0], 32'd0);
        t = inv_quarter(32'd0, 32'd0, RC[0], 31, 0);
        chk("pin_q1_x", t[63:32], 32'h481EAE9D);
        chk("pin_q1_y", t[31:0], 32'h6FC2A2C5);
        t = fwd_round(32'd0, 32'd0, RC[0], 31, 24);
        chk("pin_r0_x", t[63:32], 32'hB7E15162);
        chk("pin_r0_y", t[31:0], 32'd0);

        send(0, 32'd0, 32'd0, 3'd0);
        wait_out(0);

        for (int q = 0; q < 3; q++)
            for (int k = 0; k < 8; k++) begin
                send(q, 32'h01234567, 32'h89ABCDEF, 3'(k));
                wait_out(q);
            end

        ordy[0] = 1'b0;
        send(0, 32'hDEADBEEF, 32'h12345678, 3'd3);
        n = 0;
        while (!ov[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!ov[0]) chk("bp_timeout", 32'd1, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            iv[0] = k[0];
            ix[0] = $urandom;
        end
        iv[0] = 1'b0;
        @(posedge clk);
        #1 ordy[0] = 1'b1;
        wait_out(0);

        send(0, 32'hCAFEF00D, 32'h0BADBEEF, 3'd5);
        ix[0] = 32'hFFFFFFFF;
        iy[0] = 32'hFFFFFFFF;
        im[0] = 3'd7;
        wait_out(0);

        send(0, 32'h13579BDF, 32'h2468ACE0, 3'd2);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(ov[0]), 32'd0);
        chk("async_rst_out_x", ox[0], 32'd0);
        chk("async_rst_out_y", oy[0], 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        send(0, 32'd0, 32'd0, 3'd0);
        wait_out(0);

        push_req(0, 32'h11111111, 32'h22222222, 3'd1);
        iv[0] = 1'b1;
        wait_accept(0);
        push_req(0, 32'h33333333, 32'h44444444, 3'd4);
        wait_accept(0);
        push_req(0, 32'h55555555, 32'h66666666, 3'd6);
        wait_accept(0);
        iv[0] = 1'b0;
        wait_out(0);
        repeat (3) @(posedge clk);
        chk("all_results_seen", 32'(wr[0] - rd[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
